// File: rtl/msp430_trace_buffer_pkg.sv
// Shared definitions for the MSP430 execution-trace buffer.
package msp430_pkg;

  localparam int TRC_DATA_W  = 16;
  localparam int TRC_FLAG_W  = 4;
  localparam int TRC_DEPTH   = 32;
  localparam int TRC_ENTRY_W = 3*TRC_DATA_W + TRC_FLAG_W;

  // Capture/readout FSM encoding, visible on the State port.
  typedef enum logic [1:0] {
    TRC_IDLE  = 2'd0,
    TRC_ARMED = 2'd1,
    TRC_POST  = 2'd2,
    TRC_DONE  = 2'd3
  } trc_state_t;

  // Packed entry width {PC, Instr, Res, Flags} for arbitrary data/flag widths.
  function automatic int trc_entry_w(input int dw, input int fw);
    return 3*dw + fw;
  endfunction

endpackage

// File: rtl/msp430_trace_buffer_if.sv
// Commit stream from the core plus the valid/ready readout port.
interface msp430_trace_if #(
  parameter int DATA_W = 16,
  parameter int FLAG_W = 4
) ();
  logic              commit;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] res;
  logic [FLAG_W-1:0] flags;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_instr;
  logic [DATA_W-1:0] rd_res;
  logic [FLAG_W-1:0] rd_flags;

  // The trace buffer side.
  modport slave (
    input  commit, pc, instr, res, flags, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_res, rd_flags
  );

  // Core / debug consumer side.
  modport master (
    output commit, pc, instr, res, flags, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_res, rd_flags
  );
endinterface

// File: rtl/msp430_trace_buffer_ram.sv
// Trace storage: register file, one synchronous write port, one async read port.
// Storage is not reset; stale entries are never presented because Count gates readout.
module msp430_trace_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 52,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Write one entry per captured commit.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/msp430_trace_buffer.sv
// Execution-trace capture: circular buffer of retired instructions, PC-match
// trigger with post-trigger count, oldest-first readout over valid/ready.
module msp430_trace_buffer
  import msp430_pkg::*;
#(
  parameter  int DATA_W = TRC_DATA_W,
  parameter  int FLAG_W = TRC_FLAG_W,
  parameter  int DEPTH  = TRC_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic [AW-1:0]     post_cnt,
  msp430_trace_if.slave     tif,
  output logic [1:0]        state,
  output logic [AW:0]       count,
  output logic              overflow
);
  localparam int          ENTRY_W = trc_entry_w(DATA_W, FLAG_W);
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);

  trc_state_t       cur, nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr, post_ctr, post_lat;
  logic [ENTRY_W-1:0] rdata;
  logic             capture, trigger, rd_fire;

  // Arm pre-empts a same-cycle commit, so it never reaches the buffer.
  assign capture = tif.commit && !arm && (cur == TRC_ARMED || cur == TRC_POST);
  assign trigger = capture && (cur == TRC_ARMED) && (!trig_en || tif.pc == trig_pc);
  assign tif.rd_valid = (cur == TRC_DONE) && (count != '0);
  assign rd_fire = tif.rd_valid && tif.rd_ready && !arm;
  // When full, count's low bits are 0 and rd_ptr lands on wr_ptr (the oldest entry).
  assign rd_ptr  = wr_ptr - count[AW-1:0];

  msp430_trace_ram #(.DEPTH(DEPTH), .WIDTH(ENTRY_W), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (capture),
    .waddr (wr_ptr),
    .wdata ({tif.pc, tif.instr, tif.res, tif.flags}),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign {tif.rd_pc, tif.rd_instr, tif.rd_res, tif.rd_flags} =
    tif.rd_valid ? rdata : '0;
  assign state = cur;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= TRC_IDLE;
    else     cur <= nxt;
  end

  // Next-state: Arm restarts from any state; readout drains back to IDLE.
  always_comb begin
    nxt = cur;
    if (arm) nxt = TRC_ARMED;
    else begin
      case (cur)
        TRC_ARMED: if (trigger) nxt = (post_lat == '0) ? TRC_DONE : TRC_POST;
        TRC_POST:  if (capture && post_ctr == AW'(1)) nxt = TRC_DONE;
        TRC_DONE:  if (count == '0 || (rd_fire && count == (AW+1)'(1))) nxt = TRC_IDLE;
        default:   nxt = TRC_IDLE;
      endcase
    end
  end

  // Pointers, occupancy, post-trigger counter and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      count    <= '0;
      post_ctr <= '0;
      post_lat <= '0;
      overflow <= 1'b0;
    end else if (arm) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      post_lat <= post_cnt;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (count == FULL) overflow <= 1'b1;
        else               count    <= count + (AW+1)'(1);
        if (trigger)               post_ctr <= post_lat;
        else if (cur == TRC_POST)  post_ctr <= post_ctr - AW'(1);
      end
      if (rd_fire) count <= count - (AW+1)'(1);
    end
  end
endmodule

// File: tb/tb_msp430_trace_buffer.sv
// Directed bench for the trace buffer: a DEPTH=32 instance for most scenarios
// and a DEPTH=8 instance for the exact-fill case.
module tb_msp430_trace_buffer;
  logic        clk = 1'b0;
  logic        rst, arm, arm8, trig_en;
  logic [15:0] trig_pc;
  logic [4:0]  post_cnt;
  logic [2:0]  post_cnt8;
  logic [1:0]  state, state8;
  logic [5:0]  count;
  logic [3:0]  count8;
  logic        overflow, overflow8;

  int n_cmp = 0;
  int n_err = 0;

  msp430_trace_if #(.DATA_W(16), .FLAG_W(4)) tif ();
  msp430_trace_if #(.DATA_W(16), .FLAG_W(4)) tif8 ();

  always #5 clk = ~clk;

  msp430_trace_buffer #(.DATA_W(16), .FLAG_W(4), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .post_cnt(post_cnt), .tif(tif), .state(state), .count(count), .overflow(overflow)
  );

  msp430_trace_buffer #(.DATA_W(16), .FLAG_W(4), .DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .arm(arm8), .trig_en(trig_en), .trig_pc(trig_pc),
    .post_cnt(post_cnt8), .tif(tif8), .state(state8), .count(count8), .overflow(overflow8)
  );

  typedef struct {
    logic [15:0] pc;
    logic [1:0]  st;
    logic [5:0]  cnt;
  } vec_t;

  vec_t v1[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit_pc(input logic [15:0] p);
    tif.commit = 1'b1;
    tif.pc     = p;
    tif.instr  = p ^ 16'h4000;
    tif.res    = p + 16'h0011;
    tif.flags  = p[3:0];
    step();
    tif.commit = 1'b0;
  endtask

  task automatic do_arm(input logic te, input logic [15:0] tp, input logic [4:0] pcnt);
    trig_en  = te;
    trig_pc  = tp;
    post_cnt = pcnt;
    arm      = 1'b1;
    step();
    arm      = 1'b0;
  endtask

  // Drain the buffer, checking order, payload, hold stability and final IDLE.
  task automatic read_chk(input string nm, input logic [15:0] first,
                          input logic [15:0] stride, input int n, input bit toggle);
    int          idx  = 0;
    bit          hold = 1'b0;
    logic [15:0] held = '0;
    logic [15:0] e;
    for (int cyc = 0; cyc < 4*n + 8 && idx < n; cyc++) begin
      tif.rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      e = first + stride * 16'(idx);
      if (hold) chk({nm, " hold"}, tif.rd_pc, held);
      chk({nm, " valid"}, tif.rd_valid, 1);
      chk({nm, " pc"}, tif.rd_pc, e);
      chk({nm, " instr"}, tif.rd_instr, e ^ 16'h4000);
      hold = !tif.rd_ready;
      held = tif.rd_pc;
      if (tif.rd_ready && tif.rd_valid) idx++;
      step();
    end
    tif.rd_ready = 1'b0;
    chk({nm, " entries read"}, idx, n);
    chk({nm, " end state"}, state, 0);
    chk({nm, " end count"}, count, 0);
    chk({nm, " end valid"}, tif.rd_valid, 0);
  endtask

  initial begin
    v1[0] = '{16'h0100, 2'd2, 6'd1};
    v1[1] = '{16'h0101, 2'd2, 6'd2};
    v1[2] = '{16'h0102, 2'd2, 6'd3};
    v1[3] = '{16'h0103, 2'd3, 6'd4};
    v1[4] = '{16'h0104, 2'd3, 6'd4};
    v1[5] = '{16'h0105, 2'd3, 6'd4};

    rst = 1'b1; arm = 1'b0; arm8 = 1'b0; trig_en = 1'b0; trig_pc = '0;
    post_cnt = '0; post_cnt8 = '0;
    tif.commit = 0; tif.pc = '0; tif.instr = '0; tif.res = '0; tif.flags = '0; tif.rd_ready = 0;
    tif8.commit = 0; tif8.pc = '0; tif8.instr = '0; tif8.res = '0; tif8.flags = '0; tif8.rd_ready = 0;
    step(); step();
    rst = 1'b0;
    step();

    chk("reset state", state, 0);
    chk("reset count", count, 0);
    chk("reset overflow", overflow, 0);
    chk("reset rd_valid", tif.rd_valid, 0);
    chk("reset rd_pc", tif.rd_pc, 0);
    chk("reset state8", state8, 0);

    // IDLE ignores commits.
    commit_pc(16'h0EEE);
    chk("idle commit count", count, 0);
    chk("idle commit state", state, 0);

    // Trigger on first commit, 3 post commits; the Arm-cycle commit is dropped.
    trig_en = 1'b0; post_cnt = 5'd3; arm = 1'b1;
    tif.commit = 1'b1; tif.pc = 16'hDEAD;
    step();
    arm = 1'b0; tif.commit = 1'b0;
    chk("t1 armed state", state, 1);
    chk("t1 armed count", count, 0);
    for (int i = 0; i < 6; i++) begin
      commit_pc(v1[i].pc);
      chk($sformatf("t1 state[%0d]", i), state, v1[i].st);
      chk($sformatf("t1 count[%0d]", i), count, v1[i].cnt);
    end
    read_chk("t1 read", 16'h0100, 16'd1, 4, 1'b0);

    // Trigger late enough that the ring wraps: last 32 of 38 writes survive.
    do_arm(1'b1, 16'h0246, 5'd2);
    for (int k = 0; k < 40; k++) commit_pc(16'h0200 + 16'(2*k));
    chk("t2 state", state, 3);
    chk("t2 count", count, 32);
    chk("t2 overflow", overflow, 1);
    read_chk("t2 read", 16'h020C, 16'd2, 32, 1'b0);
    chk("t2 overflow sticky", overflow, 1);

    // Back-pressured readout; Arm also clears the sticky overflow.
    do_arm(1'b0, 16'h0000, 5'd4);
    chk("t3 overflow cleared", overflow, 0);
    for (int k = 0; k < 5; k++) commit_pc(16'h0400 + 16'(k));
    chk("t3 count", count, 5);
    read_chk("t3 toggle read", 16'h0400, 16'd1, 5, 1'b1);

    // Arm during POST restarts capture and drops its own commit.
    do_arm(1'b0, 16'h0000, 5'd3);
    commit_pc(16'h0500);
    commit_pc(16'h0501);
    chk("t4 post state", state, 2);
    chk("t4 post count", count, 2);
    arm = 1'b1; tif.commit = 1'b1; tif.pc = 16'h0502;
    step();
    arm = 1'b0; tif.commit = 1'b0;
    chk("t4 rearm state", state, 1);
    chk("t4 rearm count", count, 0);
    chk("t4 rearm overflow", overflow, 0);
    commit_pc(16'h0600);
    chk("t4 next count", count, 1);
    chk("t4 next state", state, 2);

    // Asynchronous reset during readout.
    do_arm(1'b0, 16'h0000, 5'd6);
    for (int k = 0; k < 7; k++) commit_pc(16'h0700 + 16'(k));
    chk("t5 count", count, 7);
    chk("t5 valid", tif.rd_valid, 1);
    rst = 1'b1;
    #2;
    chk("t5 async state", state, 0);
    chk("t5 async count", count, 0);
    chk("t5 async valid", tif.rd_valid, 0);
    step();
    rst = 1'b0;
    step();
    chk("t5 after state", state, 0);
    chk("t5 after count", count, 0);

    // DEPTH=8: Post_cnt=7 fills exactly, no overflow.
    trig_en = 1'b0; post_cnt8 = 3'd7; arm8 = 1'b1;
    step();
    arm8 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tif8.commit = 1'b1;
      tif8.pc     = 16'h0300 + 16'(k);
      step();
    end
    tif8.commit = 1'b0;
    chk("t6 state8", state8, 3);
    chk("t6 count8", count8, 8);
    chk("t6 overflow8", overflow8, 0);
    tif8.rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t6 valid8[%0d]", i), tif8.rd_valid, 1);
      chk($sformatf("t6 pc8[%0d]", i), tif8.rd_pc, 16'h0300 + 16'(i));
      step();
    end
    tif8.rd_ready = 1'b0;
    chk("t6 end state8", state8, 0);
    chk("t6 end count8", count8, 0);
    chk("t6 end valid8", tif8.rd_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
